fmac_norm_pipe: RTL and testbench

- Consumer of the leading-zero anticipation result in the FMAC datapath.
- Takes the unnormalized adder sum, the anticipated leading-zero count and the "no one" flag, then left-normalizes the sum.
- Corrects the anticipator's one-position underestimate and adjusts the exponent.
- Emits the rounding-ready mantissa plus sticky bit through a two-stage elastic valid/ready pipeline.

---
 rtl/fmac_norm_pipe_pkg.sv | 43 ++++
 rtl/fmac_norm_pipe_if.sv | 36 +++
 rtl/fmac_norm_pipe_shift.sv | 37 +++
 rtl/fmac_norm_pipe.sv | 88 ++++++++
 tb/tb_fmac_norm_pipe.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fmac_norm_pipe_pkg.sv
// Shared FMAC normalization definitions: datapath widths and the stage payload types
// exchanged between the normalization pipeline and its shifter.
package fpu_defs_fmac;

   localparam int C_WIDTH         = 74;
   localparam int C_LEADONE_WIDTH = 7;
   localparam int C_EXP_WIDTH     = 10;
   localparam int C_OUT_WIDTH     = 27;
   localparam int C_CNT_WIDTH     = 16;
   localparam int C_OUT_EXP_WIDTH = C_EXP_WIDTH + 2;
   localparam int C_STICKY_WIDTH  = C_WIDTH - C_OUT_WIDTH;

   // Largest legal left shift; a larger anticipated count is clamped to this.
   localparam logic [C_LEADONE_WIDTH-1:0] C_SHAMT_MAX = C_LEADONE_WIDTH'(C_WIDTH - 1);

   typedef struct packed {
      logic [C_WIDTH-1:0]         sum;
      logic [C_LEADONE_WIDTH-1:0] lzc;
      logic                       no_one;
      logic [C_EXP_WIDTH-1:0]     exp;
   } norm_stage_t;

   typedef struct packed {
      logic [C_OUT_WIDTH-1:0]     mant;
      logic                       sticky;
      logic [C_OUT_EXP_WIDTH-1:0] exp;
      logic                       zero;
      logic                       corr;
   } norm_result_t;

   function automatic logic [C_LEADONE_WIDTH-1:0] clamp_shamt(
      input logic [C_LEADONE_WIDTH-1:0] lzc
   );
      return (lzc > C_SHAMT_MAX) ? C_SHAMT_MAX : lzc;
   endfunction

   function automatic logic [C_OUT_EXP_WIDTH-1:0] sext_exp(
      input logic [C_EXP_WIDTH-1:0] exp
   );
      return {{(C_OUT_EXP_WIDTH-C_EXP_WIDTH){exp[C_EXP_WIDTH-1]}}, exp};
   endfunction

endpackage

// File: rtl/fmac_norm_pipe_if.sv
// Handshake and data bundle of the FMAC normalization pipeline; the slave modport is
// the pipeline's view, the master modport the surrounding datapath's view.
interface fmac_norm_pipe_if;
   import fpu_defs_fmac::*;

   logic                       Flush_SI;
   logic                       In_Valid_SI;
   logic                       In_Ready_SO;
   logic [C_WIDTH-1:0]         Sum_DI;
   logic [C_LEADONE_WIDTH-1:0] Lzc_DI;
   logic                       No_one_SI;
   logic [C_EXP_WIDTH-1:0]     Exp_DI;
   logic                       Out_Valid_SO;
   logic                       Out_Ready_SI;
   logic [C_OUT_WIDTH-1:0]     Mant_DO;
   logic                       Sticky_SO;
   logic [C_OUT_EXP_WIDTH-1:0] Exp_DO;
   logic                       Zero_SO;
   logic [C_CNT_WIDTH-1:0]     Corr_Cnt_DO;
   logic                       Cnt_Clr_SI;

   modport slave (
      input  Flush_SI, In_Valid_SI, Sum_DI, Lzc_DI, No_one_SI, Exp_DI,
             Out_Ready_SI, Cnt_Clr_SI,
      output In_Ready_SO, Out_Valid_SO, Mant_DO, Sticky_SO, Exp_DO, Zero_SO,
             Corr_Cnt_DO
   );

   modport master (
      output Flush_SI, In_Valid_SI, Sum_DI, Lzc_DI, No_one_SI, Exp_DI,
             Out_Ready_SI, Cnt_Clr_SI,
      input  In_Ready_SO, Out_Valid_SO, Mant_DO, Sticky_SO, Exp_DO, Zero_SO,
             Corr_Cnt_DO
   );

endinterface

// File: rtl/fmac_norm_pipe_shift.sv
// Combinational left-normalizer: shifts by the anticipated count, fixes the one-position
// underestimate, and derives mantissa, sticky and adjusted exponent.
module fmac_norm_shift
   import fpu_defs_fmac::*;
(
   input  norm_stage_t  stage,
   output norm_result_t result
);

   logic [C_LEADONE_WIDTH-1:0] shamt;
   logic [C_WIDTH-1:0]         sh_pre;
   logic [C_WIDTH-1:0]         sh;
   logic                       is_zero;
   logic                       corr;

   // NOTE: every output of a combinational block is assigned a default first so that
   // no path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      result  = '0;
      shamt   = clamp_shamt(stage.lzc);
      is_zero = stage.no_one | (stage.sum == '0);
      sh_pre  = stage.sum << shamt;
      corr    = ~is_zero & ~sh_pre[C_WIDTH-1];
      sh      = corr ? {sh_pre[C_WIDTH-2:0], 1'b0} : sh_pre;

      result.zero = is_zero;
      if (!is_zero) begin
         result.mant   = sh[C_WIDTH-1 -: C_OUT_WIDTH];
         result.sticky = |sh[C_STICKY_WIDTH-1:0];
         // Wraps on underflow on purpose; the rounder owns range handling.
         result.exp    = sext_exp(stage.exp) - C_OUT_EXP_WIDTH'(shamt)
                         - C_OUT_EXP_WIDTH'(corr);
         result.corr   = corr;
      end
   end

endmodule

// File: rtl/fmac_norm_pipe.sv
// Two-stage elastic normalization pipeline: capture register, shared shifter, output
// register, flush, and a saturating count of underestimate corrections.
module fmac_norm_pipe
   import fpu_defs_fmac::*;
(
   input  logic              Clk_CI,
   input  logic              Rst_RI,
   fmac_norm_pipe_if.slave   bus
);

   norm_stage_t            s1_q;
   norm_result_t           s2_q;
   norm_result_t           shift_res;
   logic                   v1_q;
   logic                   v2_q;
   logic                   ready1;
   logic                   ready2;
   logic                   accept;
   logic                   transfer;
   logic [C_CNT_WIDTH-1:0] cnt_q;

   assign ready2   = ~v2_q | bus.Out_Ready_SI;
   assign ready1   = ~v1_q | ready2;
   assign accept   = bus.In_Valid_SI & bus.In_Ready_SO;
   assign transfer = v2_q & bus.Out_Ready_SI;

   assign bus.In_Ready_SO = ready1 & ~bus.Flush_SI;

   fmac_norm_shift u_shift (
      .stage  (s1_q),
      .result (shift_res)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge Clk_CI or posedge Rst_RI) begin
      if (Rst_RI) begin
         v1_q <= 1'b0;
         // NOTE: data registers are reset too, so every output reads 0 during reset.
         s1_q <= '0;
      end else begin
         if (bus.Flush_SI) begin
            v1_q <= 1'b0;
         end else if (ready1) begin
            v1_q <= bus.In_Valid_SI;
         end
         if (accept) begin
            s1_q <= '{sum: bus.Sum_DI, lzc: bus.Lzc_DI, no_one: bus.No_one_SI,
                      exp: bus.Exp_DI};
         end
      end
   end

   always_ff @(posedge Clk_CI or posedge Rst_RI) begin
      if (Rst_RI) begin
         v2_q <= 1'b0;
         s2_q <= '0;
      end else begin
         if (bus.Flush_SI) begin
            v2_q <= 1'b0;
         end else if (ready2) begin
            v2_q <= v1_q;
         end
         if (v1_q && ready2 && !bus.Flush_SI) begin
            s2_q <= shift_res;
         end
      end
   end

   // Clear wins over a same-cycle increment; flush leaves the count alone.
   always_ff @(posedge Clk_CI or posedge Rst_RI) begin
      if (Rst_RI) begin
         cnt_q <= '0;
      end else if (bus.Cnt_Clr_SI) begin
         cnt_q <= '0;
      end else if (transfer && s2_q.corr && !(&cnt_q)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign bus.Out_Valid_SO = v2_q;
   assign bus.Mant_DO      = s2_q.mant;
   assign bus.Sticky_SO    = s2_q.sticky;
   assign bus.Exp_DO       = s2_q.exp;
   assign bus.Zero_SO      = s2_q.zero;
   assign bus.Corr_Cnt_DO  = cnt_q;

endmodule

// File: tb/tb_fmac_norm_pipe.sv
// Directed self-checking bench for fmac_norm_pipe: normalization cases, backpressure,
// flush, asynchronous reset and correction-counter boundaries.
module tb_fmac_norm_pipe;
   import fpu_defs_fmac::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   localparam logic [C_OUT_WIDTH-1:0] MANT_ONE = 27'h4000000;

   fmac_norm_pipe_if bus ();

   fmac_norm_pipe dut (
      .Clk_CI (clk),
      .Rst_RI (rst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [C_WIDTH-1:0] one_hot(input int pos);
      logic [C_WIDTH-1:0] v;
      v = '0;
      v[pos] = 1'b1;
      return v;
   endfunction

   task automatic drive(input logic [C_WIDTH-1:0] s, input logic [C_LEADONE_WIDTH-1:0] l,
                        input logic n, input logic [C_EXP_WIDTH-1:0] e);
      bus.In_Valid_SI = 1'b1;
      bus.Sum_DI      = s;
      bus.Lzc_DI      = l;
      bus.No_one_SI   = n;
      bus.Exp_DI      = e;
   endtask

   task automatic idle();
      bus.In_Valid_SI = 1'b0;
   endtask

   initial begin
      bus.Flush_SI     = 1'b0;
      bus.In_Valid_SI  = 1'b0;
      bus.Sum_DI       = '0;
      bus.Lzc_DI       = '0;
      bus.No_one_SI    = 1'b0;
      bus.Exp_DI       = '0;
      bus.Out_Ready_SI = 1'b1;
      bus.Cnt_Clr_SI   = 1'b0;

      // Reset state
      #1 rst = 1'b1;
      #1;
      check("rst_out_valid", bus.Out_Valid_SO, 0);
      check("rst_in_ready", bus.In_Ready_SO, 1);
      check("rst_mant", bus.Mant_DO, 0);
      check("rst_exp", bus.Exp_DO, 0);
      check("rst_zero", bus.Zero_SO, 0);
      check("rst_sticky", bus.Sticky_SO, 0);
      check("rst_cnt", bus.Corr_Cnt_DO, 0);
      @(negedge clk) rst = 1'b0;
      tick();

      // Exact leading-zero count, 2-cycle latency
      drive(one_hot(60), 7'd13, 1'b0, 10'd100);
      tick();
      idle();
      check("exact_latency1", bus.Out_Valid_SO, 0);
      tick();
      check("exact_valid", bus.Out_Valid_SO, 1);
      check("exact_mant", bus.Mant_DO, MANT_ONE);
      check("exact_sticky", bus.Sticky_SO, 0);
      check("exact_exp", bus.Exp_DO, 87);
      check("exact_zero", bus.Zero_SO, 0);
      tick();
      check("exact_cnt", bus.Corr_Cnt_DO, 0);
      check("exact_drained", bus.Out_Valid_SO, 0);

      // Underestimated count by one
      drive(one_hot(60), 7'd12, 1'b0, 10'd100);
      tick();
      idle();
      tick();
      check("under_mant", bus.Mant_DO, MANT_ONE);
      check("under_exp", bus.Exp_DO, 87);
      check("under_cnt_before", bus.Corr_Cnt_DO, 0);
      tick();
      check("under_cnt_after", bus.Corr_Cnt_DO, 1);

      // Sticky from discarded low bit
      drive(one_hot(73) | one_hot(0), 7'd0, 1'b0, 10'd5);
      tick();
      idle();
      tick();
      check("sticky_mant", bus.Mant_DO, MANT_ONE);
      check("sticky_bit", bus.Sticky_SO, 1);
      check("sticky_exp", bus.Exp_DO, 5);
      tick();

      // No-one flag forces zero
      drive(one_hot(60), 7'd5, 1'b1, 10'd33);
      tick();
      idle();
      tick();
      check("noone_zero", bus.Zero_SO, 1);
      check("noone_mant", bus.Mant_DO, 0);
      check("noone_exp", bus.Exp_DO, 0);
      check("noone_sticky", bus.Sticky_SO, 0);
      tick();

      // Zero sum without the flag
      drive('0, 7'd20, 1'b0, 10'd33);
      tick();
      idle();
      tick();
      check("zsum_zero", bus.Zero_SO, 1);
      check("zsum_exp", bus.Exp_DO, 0);
      tick();

      // Oversized count clamps to 73
      drive(one_hot(0), 7'd100, 1'b0, 10'd200);
      tick();
      idle();
      tick();
      check("clamp_mant", bus.Mant_DO, MANT_ONE);
      check("clamp_exp", bus.Exp_DO, 127);
      tick();

      // Negative exponent: -5 - 13 = -18
      drive(one_hot(60), 7'd13, 1'b0, 10'h3FB);
      tick();
      idle();
      tick();
      check("neg_exp", bus.Exp_DO, 12'hFEE);
      tick();
      check("cnt_after_singles", bus.Corr_Cnt_DO, 1);

      // Backpressure: three back-to-back inputs, only two fit
      bus.Out_Ready_SI = 1'b0;
      drive(one_hot(73), 7'd0, 1'b0, 10'd10);
      check("bp_ready_a", bus.In_Ready_SO, 1);
      tick();
      drive(one_hot(73), 7'd0, 1'b0, 10'd11);
      check("bp_ready_b", bus.In_Ready_SO, 1);
      tick();
      drive(one_hot(73), 7'd0, 1'b0, 10'd12);
      check("bp_ready_c", bus.In_Ready_SO, 0);
      check("bp_out_a", bus.Exp_DO, 10);
      tick();
      check("bp_stall_ready", bus.In_Ready_SO, 0);
      check("bp_stall_valid", bus.Out_Valid_SO, 1);
      check("bp_stall_exp", bus.Exp_DO, 10);
      bus.Out_Ready_SI = 1'b1;
      tick();
      idle();
      check("bp_out_b_valid", bus.Out_Valid_SO, 1);
      check("bp_out_b", bus.Exp_DO, 11);
      tick();
      check("bp_out_c_valid", bus.Out_Valid_SO, 1);
      check("bp_out_c", bus.Exp_DO, 12);
      tick();
      check("bp_drained", bus.Out_Valid_SO, 0);

      // Flush with two items in flight
      bus.Out_Ready_SI = 1'b0;
      drive(one_hot(73), 7'd0, 1'b0, 10'd20);
      tick();
      drive(one_hot(73), 7'd0, 1'b0, 10'd21);
      tick();
      check("fl_full", bus.Out_Valid_SO, 1);
      bus.Flush_SI = 1'b1;
      drive(one_hot(73), 7'd0, 1'b0, 10'd22);
      check("fl_in_ready", bus.In_Ready_SO, 0);
      tick();
      bus.Flush_SI = 1'b0;
      idle();
      check("fl_out_valid", bus.Out_Valid_SO, 0);
      bus.Out_Ready_SI = 1'b1;
      tick();
      check("fl_not_accepted", bus.Out_Valid_SO, 0);
      tick();
      check("fl_still_empty", bus.Out_Valid_SO, 0);
      check("fl_cnt_kept", bus.Corr_Cnt_DO, 1);

      // Asynchronous reset mid-stream
      bus.Out_Ready_SI = 1'b0;
      drive(one_hot(73), 7'd0, 1'b0, 10'd7);
      tick();
      idle();
      tick();
      check("ar_loaded", bus.Out_Valid_SO, 1);
      #2 rst = 1'b1;
      #1;
      check("ar_valid", bus.Out_Valid_SO, 0);
      check("ar_mant", bus.Mant_DO, 0);
      check("ar_exp", bus.Exp_DO, 0);
      check("ar_cnt", bus.Corr_Cnt_DO, 0);
      check("ar_in_ready", bus.In_Ready_SO, 1);
      @(negedge clk) rst = 1'b0;
      bus.Out_Ready_SI = 1'b1;
      tick();

      // Counter: 100 corrections, then saturation
      for (int i = 0; i < 100; i++) begin
         drive(one_hot(60), 7'd12, 1'b0, 10'd100);
         tick();
      end
      idle();
      tick();
      tick();
      tick();
      check("cnt_100", bus.Corr_Cnt_DO, 100);
      for (int i = 0; i < 65500; i++) begin
         drive(one_hot(60), 7'd12, 1'b0, 10'd100);
         tick();
      end
      idle();
      tick();
      tick();
      tick();
      check("cnt_sat", bus.Corr_Cnt_DO, 16'hFFFF);

      // Clear coincident with a correction transfer
      bus.Out_Ready_SI = 1'b0;
      drive(one_hot(60), 7'd12, 1'b0, 10'd100);
      tick();
      idle();
      tick();
      check("clr_pending", bus.Out_Valid_SO, 1);
      check("clr_sat_hold", bus.Corr_Cnt_DO, 16'hFFFF);
      bus.Cnt_Clr_SI   = 1'b1;
      bus.Out_Ready_SI = 1'b1;
      tick();
      bus.Cnt_Clr_SI = 1'b0;
      check("clr_cnt", bus.Corr_Cnt_DO, 0);
      check("clr_drained", bus.Out_Valid_SO, 0);
      drive(one_hot(60), 7'd12, 1'b0, 10'd100);
      tick();
      idle();
      tick();
      tick();
      check("clr_recount", bus.Corr_Cnt_DO, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
